feature_round_scheduler: RTL

Sequencer for the stage-2 feature pass of the GNN accelerator. Splits the feature vector (`N_FEAT` features) into `CHUNK`-wide slices, dispatches them to the `N_CORE` compute cores one round at a time, and waits for each round to finish. Per round it reports the base feature ID, the number of active cores, the core-enable mask, the length of the final slice and the `need64` flag. It replaces the static per-pass arithmetic with a run-time controller.

---
 rtl/gnn_s2_pkg.sv | 25 ++
 rtl/feature_round_scheduler_if.sv | 29 ++
 rtl/feature_round_scheduler_round_calc.sv | 35 +++
 rtl/feature_round_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/gnn_s2_pkg.sv
// Shared definitions for the stage-2 feature pass: sequencer states, default
// geometry and the widths of the round descriptor fields.
package gnn_s2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } state_e;

  localparam int N_FEAT_DEF = 3703;
  localparam int N_CORE_DEF = 64;
  localparam int CHUNK_DEF  = 32;

  localparam int ID_W   = 12;
  localparam int CNT_W  = 7;
  localparam int LEN_W  = 6;
  localparam int IDX_W  = 4;
  // Remaining-feature arithmetic keeps one spare bit over the ID width.
  localparam int REM_W  = 13;
  localparam int SPAN_W = 20;

endpackage

// File: rtl/feature_round_scheduler_if.sv
// Round descriptor channel between the feature round scheduler (master) and
// the compute core array (slave).
interface feature_round_scheduler_if
  import gnn_s2_pkg::*;
#(
  parameter int N_CORE = N_CORE_DEF
);
  logic              round_valid_o;
  logic              round_ready_i;
  logic              round_done_i;
  logic [ID_W-1:0]   base_id_o;
  logic [CNT_W-1:0]  core_cnt_o;
  logic [N_CORE-1:0] core_en_o;
  logic [LEN_W-1:0]  last_len_o;
  logic              need64_o;
  logic [IDX_W-1:0]  round_idx_o;

  modport master (
    output round_valid_o, base_id_o, core_cnt_o, core_en_o,
           last_len_o, need64_o, round_idx_o,
    input  round_ready_i, round_done_i
  );

  modport slave (
    input  round_valid_o, base_id_o, core_cnt_o, core_en_o,
           last_len_o, need64_o, round_idx_o,
    output round_ready_i, round_done_i
  );
endinterface

// File: rtl/feature_round_scheduler_round_calc.sv
// Combinational round geometry: how many cores the remaining features occupy,
// the enable mask, the fill of the highest core and the span this round covers.
module round_calc
  import gnn_s2_pkg::*;
#(
  parameter int N_CORE = N_CORE_DEF,
  parameter int CHUNK  = CHUNK_DEF
) (
  input  logic [REM_W-1:0]  remaining,
  output logic [CNT_W-1:0]  core_cnt,
  output logic [N_CORE-1:0] core_en,
  output logic [LEN_W-1:0]  last_len,
  output logic              need64,
  output logic [SPAN_W-1:0] span
);
  localparam int LOG2_CHUNK = $clog2(CHUNK);

  logic [REM_W-1:0]  chunks;
  logic [SPAN_W-1:0] tail;

  always_comb begin
    chunks   = (remaining + REM_W'(CHUNK - 1)) >> LOG2_CHUNK;
    core_cnt = (chunks > REM_W'(N_CORE)) ? CNT_W'(N_CORE) : CNT_W'(chunks);
    span     = SPAN_W'(core_cnt) << LOG2_CHUNK;
    // Features left for the top core once all lower cores take a full chunk.
    tail     = SPAN_W'(remaining) - (SPAN_W'(core_cnt - CNT_W'(1)) << LOG2_CHUNK);
    last_len = (SPAN_W'(remaining) > span) ? LEN_W'(CHUNK) : LEN_W'(tail);
    need64   = (core_cnt == CNT_W'(N_CORE));
    core_en  = '0;
    for (int i = 0; i < N_CORE; i++) begin
      core_en[i] = (i < int'(core_cnt));
    end
  end

endmodule

// File: rtl/feature_round_scheduler.sv
// Run-time sequencer for the stage-2 feature pass: slices N_FEAT features into
// per-core chunks and issues one round descriptor at a time to the core array.
module feature_round_scheduler
  import gnn_s2_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int N_CORE = N_CORE_DEF,
  parameter int CHUNK  = CHUNK_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic all_done_o,
  feature_round_scheduler_if.master rnd
);
  state_e            state;
  logic [REM_W-1:0]  remaining;
  logic [REM_W-1:0]  base;
  logic [IDX_W-1:0]  round_idx;
  logic [SPAN_W-1:0] span_q;
  logic [REM_W-1:0]  rem_next;

  logic [CNT_W-1:0]  calc_cnt;
  logic [N_CORE-1:0] calc_en;
  logic [LEN_W-1:0]  calc_len;
  logic              calc_need64;
  logic [SPAN_W-1:0] calc_span;

  round_calc #(
    .N_CORE (N_CORE),
    .CHUNK  (CHUNK)
  ) u_calc (
    .remaining (remaining),
    .core_cnt  (calc_cnt),
    .core_en   (calc_en),
    .last_len  (calc_len),
    .need64    (calc_need64),
    .span      (calc_span)
  );

  always_comb begin
    rem_next = (SPAN_W'(remaining) > span_q) ? (remaining - REM_W'(span_q)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      remaining         <= '0;
      base              <= '0;
      round_idx         <= '0;
      span_q            <= '0;
      busy_o            <= 1'b0;
      all_done_o        <= 1'b0;
      rnd.round_valid_o <= 1'b0;
      rnd.base_id_o     <= '0;
      rnd.core_cnt_o    <= '0;
      rnd.core_en_o     <= '0;
      rnd.last_len_o    <= '0;
      rnd.need64_o      <= 1'b0;
      rnd.round_idx_o   <= '0;
    end else begin
      all_done_o <= 1'b0;
      // Abort wins over every other event once a pass is running.
      if (abort_i && (state != ST_IDLE)) begin
        state             <= ST_IDLE;
        busy_o            <= 1'b0;
        rnd.round_valid_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i && !abort_i) begin
              remaining <= REM_W'(N_FEAT);
              base      <= '0;
              round_idx <= '0;
              busy_o    <= 1'b1;
              state     <= ST_CALC;
            end
          end
          ST_CALC: begin
            rnd.base_id_o     <= base[ID_W-1:0];
            rnd.core_cnt_o    <= calc_cnt;
            rnd.core_en_o     <= calc_en;
            rnd.last_len_o    <= calc_len;
            rnd.need64_o      <= calc_need64;
            rnd.round_idx_o   <= round_idx;
            span_q            <= calc_span;
            rnd.round_valid_o <= 1'b1;
            state             <= ST_ISSUE;
          end
          ST_ISSUE: begin
            if (rnd.round_ready_i) begin
              rnd.round_valid_o <= 1'b0;
              state             <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (rnd.round_done_i) begin
              remaining <= rem_next;
              base      <= base + REM_W'(span_q);
              round_idx <= round_idx + IDX_W'(1);
              if (rem_next == '0) begin
                all_done_o <= 1'b1;
                state      <= ST_FIN;
              end else begin
                state <= ST_CALC;
              end
            end
          end
          ST_FIN: begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
          default: begin
            busy_o            <= 1'b0;
            rnd.round_valid_o <= 1'b0;
            state             <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
